// File: rtl/mul_div_unit_if.sv
// Control and result signals between the E-stage pipeline and the multiply/divide unit.
// The pipeline side uses the master modport; mul_div_unit uses the slave modport.
interface mul_div_unit_if;
    logic        start;
    logic [2:0]  op;
    logic        hilo_we;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  rd_sel;
    logic        busy;
    logic [31:0] rdata;
    logic [31:0] hi;
    logic [31:0] lo;

    // start is a one-cycle pulse; it is honoured only while busy is low.
    modport master (
        output start, op, hilo_we, a, b, rd_sel,
        input  busy, rdata, hi, lo
    );

    modport slave (
        input  start, op, hilo_we, a, b, rd_sel,
        output busy, rdata, hi, lo
    );
endinterface

// File: rtl/mul_div_unit.sv
// E-stage multiply/divide unit that owns HI/LO and commits results after a fixed busy period.
// Optional MADD/MSUB accumulate ops are enabled by defining MDU_MADD_EN.
module mul_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic           clk,
    input  logic           reset,
    mul_div_unit_if.slave  bus
);
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
`ifdef MDU_MADD_EN
    localparam logic [2:0] OP_MADD  = 3'd6;
    localparam logic [2:0] OP_MSUB  = 3'd7;
`endif
    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t      state;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    logic signed [63:0] sa, sb;
    logic [63:0] prod_s, prod_u, result;
    logic        div_signed, a_neg, b_neg, wr_result;
    logic [31:0] a_abs, b_abs, divisor, q_u, r_u, div_q, div_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= 4'd0;
            op_q  <= 3'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            hi_q  <= 32'd0;
            lo_q  <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
            op_q  <= op_d;
            a_q   <= a_d;
            b_q   <= b_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end

    // Result datapath works on the latched operands; accumulates see HI/LO at the commit edge.
    always_comb begin
        sa         = {{32{a_q[31]}}, a_q};
        sb         = {{32{b_q[31]}}, b_q};
        prod_s     = sa * sb;
        prod_u     = {32'd0, a_q} * {32'd0, b_q};
        div_signed = (op_q == OP_DIV);
        a_neg      = div_signed & a_q[31];
        b_neg      = div_signed & b_q[31];
        a_abs      = a_neg ? -a_q : a_q;
        b_abs      = b_neg ? -b_q : b_q;
        divisor    = (b_abs == 32'd0) ? 32'd1 : b_abs;
        q_u        = a_abs / divisor;
        r_u        = a_abs % divisor;
        div_q      = (a_neg ^ b_neg) ? -q_u : q_u;
        div_r      = a_neg ? -r_u : r_u;
        result     = {hi_q, lo_q};
        wr_result  = 1'b1;
        case (op_q)
            OP_MULT:  result = prod_s;
            OP_MULTU: result = prod_u;
            OP_DIV, OP_DIVU: begin
                result    = {div_r, div_q};
                wr_result = (b_q != 32'd0);
            end
`ifdef MDU_MADD_EN
            OP_MADD:  result = {hi_q, lo_q} + prod_s;
            OP_MSUB:  result = {hi_q, lo_q} - prod_s;
`endif
            default: ;
        endcase
    end

    always_comb begin
        state = (cnt_q != 4'd0) ? ST_BUSY : ST_IDLE;
        cnt_d = cnt_q;
        op_d  = op_q;
        a_d   = a_q;
        b_d   = b_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        if (state == ST_BUSY) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1 && wr_result) begin
                hi_d = result[63:32];
                lo_d = result[31:0];
            end
        end else if (bus.start) begin
            case (bus.op)
                OP_MULT, OP_MULTU: begin
                    op_d  = bus.op;
                    a_d   = bus.a;
                    b_d   = bus.b;
                    cnt_d = MULT_CNT;
                end
                OP_DIV, OP_DIVU: begin
                    op_d  = bus.op;
                    a_d   = bus.a;
                    b_d   = bus.b;
                    cnt_d = DIV_CNT;
                end
                OP_MTHI: if (bus.hilo_we) hi_d = bus.a;
                OP_MTLO: if (bus.hilo_we) lo_d = bus.a;
`ifdef MDU_MADD_EN
                OP_MADD, OP_MSUB: begin
                    op_d  = bus.op;
                    a_d   = bus.a;
                    b_d   = bus.b;
                    cnt_d = MULT_CNT;
                end
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.busy = (state == ST_BUSY);
        bus.hi   = hi_q;
        bus.lo   = lo_q;
        case (bus.rd_sel)
            2'd1:    bus.rdata = hi_q;
            2'd2:    bus.rdata = lo_q;
            default: bus.rdata = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized and directed checks of mul_div_unit against a plain-arithmetic HI/LO model.
// Build with +define+MDU_MADD_EN to exercise the accumulate ops.
module tb_mul_div_unit;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    logic [31:0] m_hi, m_lo;
    logic [63:0] exp_q[$];

    mul_div_unit_if bus ();

    mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [63:0] cur);
        longint sp;
        longint unsigned up;
        int sa, sb;
        sp = longint'($signed(a)) * longint'($signed(b));
        up = 64'(a) * 64'(b);
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            3'd0: return sp;
            3'd1: return up;
            3'd2: begin
                if (b == 32'd0) return cur;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            3'd3: begin
                if (b == 32'd0) return cur;
                return {a % b, a / b};
            end
`ifdef MDU_MADD_EN
            3'd6: return cur + sp;
            3'd7: return cur - sp;
`endif
            default: return cur;
        endcase
    endfunction

    function automatic int exp_cycles(input logic [2:0] op);
        case (op)
            3'd0, 3'd1: return 5;
            3'd2, 3'd3: return 10;
`ifdef MDU_MADD_EN
            3'd6, 3'd7: return 5;
`endif
            default: return 0;
        endcase
    endfunction

    task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic we);
        logic [63:0] r;
        if (op == 3'd4) begin
            if (we) m_hi = a;
        end else if (op == 3'd5) begin
            if (we) m_lo = a;
        end else begin
            r    = ref_result(op, a, b, {m_hi, m_lo});
            m_hi = r[63:32];
            m_lo = r[31:0];
        end
        exp_q.push_back({m_hi, m_lo});
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic we);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.op      = op;
        bus.a       = a;
        bus.b       = b;
        bus.hilo_we = we;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.hilo_we = 1'b0;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
            cycles++;
        end
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic we, output int cycles, output logic [63:0] exp);
        issue(op, a, b, we);
        model_apply(op, a, b, we);
        wait_idle(cycles);
        exp = exp_q.pop_front();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.start = 1'b0; bus.op = 3'd0; bus.hilo_we = 1'b0;
        bus.a = 32'd0; bus.b = 32'd0; bus.rd_sel = 2'd1;
        m_hi = 32'd0; m_lo = 32'd0;
        #12;
        n_checks++;
        if ({bus.busy, bus.hi, bus.lo, bus.rdata} !== 97'd0)
            $display("FAIL reset_state: busy=%b hi=%h lo=%h rdata=%h, required all 0",
                     bus.busy, bus.hi, bus.lo, bus.rdata);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_mult;
        int c;
        logic [63:0] e;
        logic [2:0] op;
        logic [31:0] a, b;
        do_op(3'd0, 32'hFFFF_FFFF, 32'd2, 1'b0, c, e);
        n_checks++;
        if (c !== 5) $display("FAIL mult_busy: got %0d cycles, required 5", c); else n_pass++;
        n_checks++;
        if ({bus.hi, bus.lo} !== 64'hFFFF_FFFF_FFFF_FFFE)
            $display("FAIL mult_result: got %h_%h, required ffffffff_fffffffe", bus.hi, bus.lo);
        else n_pass++;
        do_op(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, c, e);
        n_checks++;
        if ({bus.hi, bus.lo} !== 64'h0000_0001_FFFF_FFFE)
            $display("FAIL multu_result: got %h_%h, required 00000001_fffffffe", bus.hi, bus.lo);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            op = 3'($urandom_range(0, 1));
            a  = $urandom;
            b  = $urandom;
            do_op(op, a, b, 1'b0, c, e);
            n_checks++;
            if (c !== 5 || {bus.hi, bus.lo} !== e)
                $display("FAIL mult_rand op=%0d a=%h b=%h: got %0d cycles %h_%h, required 5 cycles %h",
                         op, a, b, c, bus.hi, bus.lo, e);
            else n_pass++;
            bus.rd_sel = 2'($urandom_range(0, 3));
            #1;
            n_checks++;
            if (bus.rdata !== (bus.rd_sel == 2'd1 ? m_hi : bus.rd_sel == 2'd2 ? m_lo : 32'd0))
                $display("FAIL rdata_sel%0d: got %h (model hi=%h lo=%h)", bus.rd_sel, bus.rdata, m_hi, m_lo);
            else n_pass++;
        end
    endtask

    task automatic test_div;
        int c;
        logic [63:0] e;
        logic [2:0] op;
        logic [31:0] a, b;
        do_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, c, e);
        n_checks++;
        if (c !== 10) $display("FAIL div_busy: got %0d cycles, required 10", c); else n_pass++;
        n_checks++;
        if ({bus.hi, bus.lo} !== 64'hFFFF_FFFF_FFFF_FFFD)
            $display("FAIL div_neg: got %h_%h, required ffffffff_fffffffd", bus.hi, bus.lo);
        else n_pass++;
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, c, e);
        n_checks++;
        if ({bus.hi, bus.lo} !== 64'h0000_0000_8000_0000)
            $display("FAIL div_overflow: got %h_%h, required 00000000_80000000", bus.hi, bus.lo);
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            op = 3'($urandom_range(2, 3));
            a  = $urandom;
            b  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            do_op(op, a, b, 1'b0, c, e);
            n_checks++;
            if (c !== 10 || {bus.hi, bus.lo} !== e)
                $display("FAIL div_rand op=%0d a=%h b=%h: got %0d cycles %h_%h, required 10 cycles %h",
                         op, a, b, c, bus.hi, bus.lo, e);
            else n_pass++;
        end
    endtask

    task automatic test_div_zero;
        int c;
        logic [63:0] e;
        do_op(3'd4, 32'h1111_1111, 32'd0, 1'b1, c, e);
        do_op(3'd5, 32'h2222_2222, 32'd0, 1'b1, c, e);
        do_op(3'd3, 32'h1234_5678, 32'd0, 1'b0, c, e);
        n_checks++;
        if (c !== 10 || {bus.hi, bus.lo} !== 64'h1111_1111_2222_2222)
            $display("FAIL div_zero: got %0d cycles %h_%h, required 10 cycles 11111111_22222222",
                     c, bus.hi, bus.lo);
        else n_pass++;
    endtask

    task automatic test_mthi_mtlo;
        issue(3'd4, 32'hDEAD_BEEF, 32'd0, 1'b1);
        model_apply(3'd4, 32'hDEAD_BEEF, 32'd0, 1'b1);
        void'(exp_q.pop_front());
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'hDEAD_BEEF)
            $display("FAIL mthi: got busy=%b hi=%h, required busy=0 hi=deadbeef", bus.busy, bus.hi);
        else n_pass++;
        bus.rd_sel = 2'd1;
        #1;
        n_checks++;
        if (bus.rdata !== 32'hDEAD_BEEF) $display("FAIL rdata_hi: got %h, required deadbeef", bus.rdata);
        else n_pass++;
        issue(3'd5, 32'hAAAA_5555, 32'd0, 1'b0);
        @(negedge clk);
        n_checks++;
        if (bus.lo !== m_lo || bus.busy !== 1'b0)
            $display("FAIL mtlo_no_we: got lo=%h busy=%b, required lo=%h busy=0", bus.lo, bus.busy, m_lo);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        int c;
        logic [63:0] e;
        logic [31:0] old_lo;
        do_op(3'd5, 32'h1234_5678, 32'd0, 1'b1, c, e);
        old_lo = 32'h1234_5678;
        issue(3'd1, 32'd3, 32'd7, 1'b0);
        model_apply(3'd1, 32'd3, 32'd7, 1'b0);
        e = exp_q.pop_front();
        bus.rd_sel = 2'd2;
        c = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 2) begin
                bus.start = 1'b0;
                bus.hilo_we = 1'b0;
                n_checks++;
                if (bus.lo !== old_lo) $display("FAIL mtlo_while_busy: got lo=%h, required %h", bus.lo, old_lo);
                else n_pass++;
            end
            if (!bus.busy) break;
            c++;
            if (i == 1) begin
                #1;
                n_checks++;
                if (bus.rdata !== old_lo)
                    $display("FAIL rdata_during_busy: got %h, required %h", bus.rdata, old_lo);
                else n_pass++;
                bus.start = 1'b1; bus.op = 3'd5; bus.hilo_we = 1'b1; bus.a = 32'hBAD0_BAD0;
            end
        end
        n_checks++;
        if (c !== 5 || {bus.hi, bus.lo} !== e)
            $display("FAIL busy_inflight: got %0d cycles %h_%h, required 5 cycles %h", c, bus.hi, bus.lo, e);
        else n_pass++;
    endtask

    task automatic test_madd;
        int c;
        logic [63:0] e;
        do_op(3'd4, 32'd0, 32'd0, 1'b1, c, e);
        do_op(3'd5, 32'hFFFF_FFFF, 32'd0, 1'b1, c, e);
        do_op(3'd6, 32'd1, 32'd1, 1'b0, c, e);
`ifdef MDU_MADD_EN
        n_checks++;
        if (c !== 5 || {bus.hi, bus.lo} !== 64'h0000_0001_0000_0000)
            $display("FAIL madd: got %0d cycles %h_%h, required 5 cycles 00000001_00000000", c, bus.hi, bus.lo);
        else n_pass++;
`else
        n_checks++;
        if (c !== 0 || {bus.hi, bus.lo} !== 64'h0000_0000_FFFF_FFFF)
            $display("FAIL madd_disabled: got %0d cycles %h_%h, required 0 cycles 00000000_ffffffff",
                     c, bus.hi, bus.lo);
        else n_pass++;
`endif
        for (int i = 0; i < 3; i++) begin
            do_op(3'($urandom_range(6, 7)), $urandom, $urandom, 1'b0, c, e);
            n_checks++;
            if (c !== exp_cycles(3'd6) || {bus.hi, bus.lo} !== e)
                $display("FAIL madd_rand: got %0d cycles %h_%h, required %0d cycles %h",
                         c, bus.hi, bus.lo, exp_cycles(3'd6), e);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid;
        int c;
        logic [63:0] e;
        do_op(3'd4, 32'h5555_5555, 32'd0, 1'b1, c, e);
        do_op(3'd5, 32'h6666_6666, 32'd0, 1'b1, c, e);
        bus.rd_sel = 2'd2;
        issue(3'd2, 32'd100, 32'd7, 1'b0);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        exp_q.delete();
        n_checks++;
        if ({bus.busy, bus.hi, bus.lo, bus.rdata} !== 97'd0)
            $display("FAIL reset_mid: busy=%b hi=%h lo=%h rdata=%h, required all 0",
                     bus.busy, bus.hi, bus.lo, bus.rdata);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.hi, bus.lo} !== {1'b0, m_hi, m_lo})
            $display("FAIL reset_no_commit: busy=%b hi=%h lo=%h, required busy=0 hi=0 lo=0",
                     bus.busy, bus.hi, bus.lo);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_mthi_mtlo();
        test_back_to_back();
        test_madd();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- E-stage multiply/divide unit. Consumes the start, HI/LO write and HI/LO read-select controls that the D->E pipeline register delivers, and owns the architectural HI/LO registers.
- Provides a `busy` flag to the hazard unit. Hazard logic stalls D-stage mult/div/mfhi/mflo/mthi/mtlo while (start | busy).
- Provides a combinational HI/LO read value to the E-stage result mux.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (and MADD/MSUB when enabled); legal range 1..15.
- DIV_CYCLES, 10, busy cycles for DIV/DIVU; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse: a mult/div-class op is in E this cycle.
- op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MSUB.
- hilo_we  input  1  qualifies MTHI/MTLO (ops 4/5); ignored for other ops.
- a  input  32  forwarded rs operand.
- b  input  32  forwarded rt operand.
- rd_sel  input  2  read select: 1 = HI, 2 = LO, 0 or 3 = none.
- busy  output  1  operation in progress.
- rdata  output  32  HI/LO read value.
- hi  output  32  HI register, for debug.
- lo  output  32  LO register, for debug.

Behaviour:
- Reset (async, any time, including mid-operation):
  - HI = 0, LO = 0, busy = 0, counter = 0, operand latches = 0.
  - Any pending result is discarded.
- State: a 4-bit down-counter `cnt`; busy = (cnt != 0).
  - IDLE: cnt == 0. BUSY: cnt != 0.
- IDLE, start=1, op in {0,1,2,3}:
  - Latch a, b and op.
  - Load cnt with MULT_CYCLES (ops 0/1) or DIV_CYCLES (ops 2/3).
- BUSY:
  - cnt decrements on every edge.
  - On the edge where cnt goes 1->0, HI/LO are written with the result.
  - busy is high for exactly N cycles after the start edge; new HI/LO are visible in the first cycle with busy=0.
- MULT: {HI,LO} = signed 64-bit product.
- MULTU: {HI,LO} = unsigned 64-bit product.
- DIV: LO = signed quotient, truncated toward zero; HI = remainder, with the sign of the dividend.
  - Special case 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- DIVU: LO = unsigned quotient, HI = unsigned remainder.
- Divide by zero (b latched == 0):
  - Full DIV_CYCLES busy period still occurs.
  - HI/LO are left unchanged.
- MTHI/MTLO:
  - Condition: IDLE, start=1, op 4/5, hilo_we=1.
  - Effect: HI (op 4) or LO (op 5) = a at that edge; busy stays 0.
  - With hilo_we=0 the op is a no-op.
- start while BUSY: ignored entirely (the hazard unit guarantees this never happens). The in-flight op completes unaffected.
- Ops 6/7: no-op unless MDU_MADD_EN is defined (see Optional Feature).
- rdata (combinational):
  - rd_sel 1 -> HI; rd_sel 2 -> LO; else 0.
  - While BUSY, rdata returns the pre-operation HI/LO.
- The result may be computed at the start edge and held internally; only the write timing is architecturally visible.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - Op 6 MADD: {HI,LO} = {HI,LO} + signed(a)*signed(b).
  - Op 7 MSUB: {HI,LO} = {HI,LO} - signed(a)*signed(b).
  - Both take a MULT_CYCLES busy period; 64-bit wrap-around arithmetic.
  - The accumulate uses the HI/LO value at the commit edge.
- Not defined: ops 6/7 do not set busy and do not modify HI/LO.

Test Plan:
- Multiply pair:
  - reset, then MULT a=0xFFFFFFFF b=0x00000002 -> busy=1 for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- Signed divide:
  - DIV a=0xFFFFFFF9 (-7) b=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Divide by zero: HI=0x11111111, LO=0x22222222, then DIVU b=0 -> busy 10 cycles; HI/LO unchanged.
- MTHI/MTLO and read-during-busy:
  - MTHI a=0xDEADBEEF (hilo_we=1) -> HI=0xDEADBEEF next cycle, busy stays 0; rd_sel=1 -> rdata=0xDEADBEEF.
  - Start a MULT, then assert start with MTLO while busy -> LO is not written by MTLO; rd_sel=2 during busy returns the old LO.
- Reset mid-operation: DIV started, reset asserted asynchronously at cycle 4 (not clock-aligned) -> busy, HI, LO, rdata all 0 immediately; no write after reset release.
- MADD (with MDU_MADD_EN): HI=0, LO=0xFFFFFFFF, MADD a=1 b=1 -> HI=1, LO=0.
- MADD (without MDU_MADD_EN): op 6 -> busy stays 0, HI/LO unchanged.
